// File: rtl/spi_reg_sequencer.sv
// SPI command sequencer: turns the spi_slave byte stream into
// register-bank burst reads and writes, all in the sys_clk domain.
module spi_reg_sequencer #(
    parameter int unsigned ADDR_W   = 4,
    parameter bit          AUTO_INC = 1'b1,
    parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              data_rdy,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic              tx_latch,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR,
        RD_FETCH,
        RD_LOAD,
        RD,
        ERR
    } state_t;

    state_t            state_q, state_d;
    logic              ss_meta_q, ss_meta_d;
    logic              ss_s_q, ss_s_d;
    logic              ss_prev_q, ss_prev_d;
    logic [1:0]        init_q, init_d;
    logic              armed_q, armed_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_latch_q, tx_latch_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]        reg_wdata_q, reg_wdata_d;
    logic              reg_we_q, reg_we_d;
    logic              reg_re_q, reg_re_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              frame_start;
    logic              frame_end;
    logic [6:0]        cmd_hi;
    logic              cmd_bad;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] wr_addr;

    // Arm only once the synchroniser holds real samples showing ss high,
    // so an ss already low at reset release never opens a frame.
    always_comb begin
        ss_meta_d = ss;
        ss_s_d    = ss_meta_q;
        ss_prev_d = ss_s_q;
        init_d    = {init_q[0], 1'b1};
        armed_d   = armed_q | (init_q[1] & ss_s_q);
    end

    assign frame_start = armed_q & ss_prev_q & ~ss_s_q;
    assign frame_end   = ~ss_prev_q & ss_s_q;

    assign cmd_hi   = rx_byte[6:0] >> ADDR_W;
    assign cmd_bad  = |cmd_hi;
    assign addr_inc = reg_addr_q + ADDR_W'(1);
    // A write issued last cycle advances the address this cycle.
    assign wr_addr  = (reg_we_q && AUTO_INC) ? addr_inc : reg_addr_q;

    always_comb begin
        state_d     = state_q;
        tx_byte_d   = tx_byte_q;
        tx_latch_d  = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        err_d       = err_q;

        if (frame_end) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_d    = CMD;
                        err_d      = 1'b0;
                        tx_byte_d  = 8'h00;
                        tx_latch_d = 1'b1;
                    end
                end
                CMD: begin
                    if (data_rdy) begin
                        if (cmd_bad) begin
                            state_d    = ERR;
                            err_d      = 1'b1;
                            tx_byte_d  = ERR_BYTE;
                            tx_latch_d = 1'b1;
                        end else begin
                            reg_addr_d = rx_byte[ADDR_W-1:0];
                            if (rx_byte[7]) begin
                                state_d = WR;
                            end else begin
                                state_d  = RD_FETCH;
                                reg_re_d = 1'b1;
                            end
                        end
                    end
                end
                WR: begin
                    reg_addr_d = wr_addr;
                    if (data_rdy) begin
                        reg_we_d    = 1'b1;
                        reg_wdata_d = rx_byte;
                    end
                end
                RD_FETCH: begin
                    state_d = RD_LOAD;
                end
                RD_LOAD: begin
                    tx_byte_d = reg_rdata;
                    state_d   = RD;
                end
                RD: begin
                    if (data_rdy) begin
                        if (AUTO_INC) begin
                            reg_addr_d = addr_inc;
                        end
                        reg_re_d = 1'b1;
                        state_d  = RD_FETCH;
                    end
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ss_meta_q   <= 1'b1;
            ss_s_q      <= 1'b1;
            ss_prev_q   <= 1'b1;
            init_q      <= 2'b00;
            armed_q     <= 1'b0;
            tx_byte_q   <= 8'h00;
            tx_latch_q  <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_meta_q   <= ss_meta_d;
            ss_s_q      <= ss_s_d;
            ss_prev_q   <= ss_prev_d;
            init_q      <= init_d;
            armed_q     <= armed_d;
            tx_byte_q   <= tx_byte_d;
            tx_latch_q  <= tx_latch_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Read data is forwarded straight from the bank in RD_LOAD so the
    // latch lands two cycles after the triggering byte.
    assign tx_byte   = (state_q == RD_LOAD) ? reg_rdata : tx_byte_q;
    assign tx_latch  = tx_latch_q | (state_q == RD_LOAD);
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
